// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter that shares one SPI master among NUM_REQ requesters,
// each owning one slave-select line.
module spi_master_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            Req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqTxData,
  input  logic [NUM_REQ*2-1:0]          ReqClkDiv,
  output logic [NUM_REQ-1:0]            Grant,
  output logic [NUM_REQ-1:0]            Ack,
  output logic                          Err,
  output logic [DATA_WIDTH-1:0]         RxData,
  output logic                          Busy,
  output logic                          SpiStart,
  output logic [DATA_WIDTH-1:0]         SpiTxData,
  output logic [1:0]                    SpiClkDiv,
  input  logic                          SpiDone,
  input  logic [DATA_WIDTH-1:0]         SpiRxData,
  input  logic                          SpiSS,
  output logic [NUM_REQ-1:0]            SsOut
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_C = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_COMPLETE  = 3'd4,
    ST_ABORT     = 3'd5,
    ST_GAP       = 3'd6
  } state_t;

  state_t                  state_r, state_s;
  logic [NUM_REQ-1:0]      grant_r, grant_s;
  logic [NUM_REQ-1:0]      ack_r, ack_s;
  logic                    err_r, err_s;
  logic [DATA_WIDTH-1:0]   rx_data_r, rx_data_s;
  logic                    busy_r, busy_s;
  logic                    spi_start_r, spi_start_s;
  logic [DATA_WIDTH-1:0]   spi_tx_data_r, spi_tx_data_s;
  logic [1:0]              spi_clk_div_r, spi_clk_div_s;
  logic [IDX_W-1:0]        last_r, last_s;
  logic [IDX_W-1:0]        idx_r, idx_s;
  logic [7:0]              cnt_r, cnt_s;
  logic                    win_found_s;
  logic [IDX_W-1:0]        win_idx_s;

  // Round-robin scan starting just after the last served requester.
  always_comb begin
    int pos;
    win_found_s = 1'b0;
    win_idx_s   = last_r;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = (int'(last_r) + k >= NUM_REQ) ? int'(last_r) + k - NUM_REQ : int'(last_r) + k;
      if (!win_found_s && Req[pos]) begin
        win_found_s = 1'b1;
        win_idx_s   = IDX_W'(pos);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and next-output logic; Ack/Err/SpiStart are pulses by default.
  always_comb begin
    state_s       = state_r;
    grant_s       = grant_r;
    ack_s         = {NUM_REQ{1'b0}};
    err_s         = 1'b0;
    rx_data_s     = rx_data_r;
    spi_start_s   = 1'b0;
    spi_tx_data_s = spi_tx_data_r;
    spi_clk_div_s = spi_clk_div_r;
    last_s        = last_r;
    idx_s         = idx_r;
    cnt_s         = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          grant_s       = ONE_C << win_idx_s;
          idx_s         = win_idx_s;
          spi_tx_data_s = ReqTxData[int'(win_idx_s)*DATA_WIDTH +: DATA_WIDTH];
          spi_clk_div_s = ReqClkDiv[int'(win_idx_s)*2 +: 2];
          spi_start_s   = 1'b1;
          state_s       = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        cnt_s   = 8'd0;
        state_s = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!SpiDone) begin
          state_s = ST_WAIT_DONE;
        end else if (cnt_r + 8'd1 == TIMEOUT_C) begin
          cnt_s   = cnt_r + 8'd1;
          state_s = ST_ABORT;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (SpiDone) begin
          state_s = ST_COMPLETE;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      ST_COMPLETE: begin
        rx_data_s = SpiRxData;
        ack_s     = grant_r;
        grant_s   = {NUM_REQ{1'b0}};
        last_s    = idx_r;
        state_s   = ST_GAP;
      end
      ST_ABORT: begin
        ack_s   = grant_r;
        err_s   = 1'b1;
        grant_s = {NUM_REQ{1'b0}};
        last_s  = idx_r;
        state_s = ST_GAP;
      end
      ST_GAP: begin
        state_s = ST_IDLE;
      end
      default: begin
        grant_s = {NUM_REQ{1'b0}};
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r       <= ST_IDLE;
      grant_r       <= {NUM_REQ{1'b0}};
      ack_r         <= {NUM_REQ{1'b0}};
      err_r         <= 1'b0;
      rx_data_r     <= {DATA_WIDTH{1'b0}};
      busy_r        <= 1'b0;
      spi_start_r   <= 1'b0;
      spi_tx_data_r <= {DATA_WIDTH{1'b0}};
      spi_clk_div_r <= 2'b00;
      last_r        <= LAST_RST;
      idx_r         <= {IDX_W{1'b0}};
      cnt_r         <= 8'd0;
    end else begin
      state_r       <= state_s;
      grant_r       <= grant_s;
      ack_r         <= ack_s;
      err_r         <= err_s;
      rx_data_r     <= rx_data_s;
      busy_r        <= busy_s;
      spi_start_r   <= spi_start_s;
      spi_tx_data_r <= spi_tx_data_s;
      spi_clk_div_r <= spi_clk_div_s;
      last_r        <= last_s;
      idx_r         <= idx_s;
      cnt_r         <= cnt_s;
    end
  end

  // Slave-select fan-out follows the master's SS only on the granted line.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      SsOut[i] = grant_r[i] ? SpiSS : 1'b1;
    end
  end

  assign Grant     = grant_r;
  assign Ack       = ack_r;
  assign Err       = err_r;
  assign RxData    = rx_data_r;
  assign Busy      = busy_r;
  assign SpiStart  = spi_start_r;
  assign SpiTxData = spi_tx_data_r;
  assign SpiClkDiv = spi_clk_div_r;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed testbench for spi_master_arbiter with a small behavioural SPI master.
module tb_spi_master_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [3:0]  Req;
  logic [31:0] ReqTxData;
  logic [7:0]  ReqClkDiv;
  logic [3:0]  Grant, Ack, SsOut;
  logic        Err, Busy, SpiStart;
  logic [7:0]  RxData, SpiTxData;
  logic [1:0]  SpiClkDiv;
  logic        m_done, m_ss, m_busy;
  logic [7:0]  m_rx;
  logic [3:0]  m_cnt;
  logic        stuck;
  logic [7:0]  rx_value;
  int          start_cnt = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  spi_master_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .TIMEOUT(15)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqTxData(ReqTxData), .ReqClkDiv(ReqClkDiv),
    .Grant(Grant), .Ack(Ack), .Err(Err), .RxData(RxData), .Busy(Busy),
    .SpiStart(SpiStart), .SpiTxData(SpiTxData), .SpiClkDiv(SpiClkDiv),
    .SpiDone(m_done), .SpiRxData(m_rx), .SpiSS(m_ss), .SsOut(SsOut)
  );

  always #5 Clk = ~Clk;

  // Master model: 4-cycle transfer, or ignores Start entirely when stuck.
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_done <= 1'b1; m_ss <= 1'b1; m_busy <= 1'b0; m_cnt <= 4'd0; m_rx <= 8'h00;
    end else if (!m_busy && SpiStart) begin
      if (stuck) begin
        m_rx <= rx_value;
      end else begin
        m_busy <= 1'b1; m_done <= 1'b0; m_ss <= 1'b0; m_cnt <= 4'd4;
      end
    end else if (m_busy) begin
      if (m_cnt == 4'd1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_ss <= 1'b1; m_rx <= rx_value;
      end else begin
        m_cnt <= m_cnt - 4'd1;
      end
    end
  end

  always @(posedge Clk) begin
    if (!Reset && SpiStart) start_cnt <= start_cnt + 1;
  end

  task automatic wait_ack(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge Clk);
      if (Ack != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    Req = 4'b0000; stuck = 1'b0; rx_value = 8'h00;
    ReqTxData = {8'h44, 8'hA5, 8'h22, 8'h11};
    ReqClkDiv = {2'b11, 2'b00, 2'b11, 2'b11};
    #1 Reset = 1'b1;
    @(negedge Clk); @(negedge Clk);
    total_cnt++; if (Grant !== 4'b0000) $display("FAIL reset_grant: got %b want 0000", Grant); else pass_cnt++;
    total_cnt++; if ({Ack, Err, Busy, SpiStart} !== 7'b0) $display("FAIL reset_pulses: got %b want 0000000", {Ack, Err, Busy, SpiStart}); else pass_cnt++;
    total_cnt++; if ({RxData, SpiTxData, SpiClkDiv} !== 18'h0) $display("FAIL reset_data: got %h want 00000", {RxData, SpiTxData, SpiClkDiv}); else pass_cnt++;
    total_cnt++; if (SsOut !== 4'b1111) $display("FAIL reset_ssout: got %b want 1111", SsOut); else pass_cnt++;
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_single;
    bit ok;
    bit seen;
    rx_value = 8'h3C;
    Req = 4'b0100;
    @(negedge Clk);
    total_cnt++; if (Grant !== 4'b0100) $display("FAIL single_grant: got %b want 0100", Grant); else pass_cnt++;
    total_cnt++; if (SpiStart !== 1'b1 || Busy !== 1'b1) $display("FAIL single_start: got start=%b busy=%b want 1 1", SpiStart, Busy); else pass_cnt++;
    total_cnt++; if (SpiTxData !== 8'hA5 || SpiClkDiv !== 2'b00) $display("FAIL single_latch: got %h/%b want a5/00", SpiTxData, SpiClkDiv); else pass_cnt++;
    @(negedge Clk);
    total_cnt++; if (SpiStart !== 1'b0) $display("FAIL single_start_pulse: got %b want 0", SpiStart); else pass_cnt++;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m_ss == 1'b0) begin seen = 1'b1; break; end
      @(negedge Clk);
    end
    total_cnt++; if (!seen || SsOut !== 4'b1011) $display("FAIL single_ssout: got %b (seen=%b) want 1011", SsOut, seen); else pass_cnt++;
    wait_ack(30, ok);
    total_cnt++; if (!ok || Ack !== 4'b0100) $display("FAIL single_ack: got %b (ok=%b) want 0100", Ack, ok); else pass_cnt++;
    total_cnt++; if (RxData !== 8'h3C || Err !== 1'b0) $display("FAIL single_rx: got %h err=%b want 3c err=0", RxData, Err); else pass_cnt++;
    Req = 4'b0000;
    @(negedge Clk);
    total_cnt++; if (Ack !== 4'b0000) $display("FAIL single_ack_pulse: got %b want 0000", Ack); else pass_cnt++;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_round_robin;
    bit ok;
    int base;
    logic [3:0] exp_ack [5];
    exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    Reset = 1'b1; Req = 4'b1111;
    @(negedge Clk);
    Reset = 1'b0;
    base = start_cnt;
    for (int k = 0; k < 5; k++) begin
      wait_ack(30, ok);
      total_cnt++; if (!ok || Ack !== exp_ack[k]) $display("FAIL rr_order_%0d: got %b (ok=%b) want %b", k, Ack, ok, exp_ack[k]); else pass_cnt++;
      total_cnt++; if (start_cnt - base !== k + 1) $display("FAIL rr_starts_%0d: got %0d want %0d", k, start_cnt - base, k + 1); else pass_cnt++;
    end
    Req = 4'b0000;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_priority;
    bit ok;
    Req = 4'b0101;
    wait_ack(30, ok);
    total_cnt++; if (!ok || Ack !== 4'b0100) $display("FAIL prio_first: got %b (ok=%b) want 0100", Ack, ok); else pass_cnt++;
    Req = 4'b0001;
    wait_ack(30, ok);
    total_cnt++; if (!ok || Ack !== 4'b0001) $display("FAIL prio_second: got %b (ok=%b) want 0001", Ack, ok); else pass_cnt++;
    Req = 4'b0000;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_timeout;
    bit ok;
    bit seen;
    int n;
    stuck = 1'b1; rx_value = 8'hEE;
    Req = 4'b0010;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (SpiStart) begin seen = 1'b1; break; end
    end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      n++;
      if (Ack != 4'b0000) break;
    end
    total_cnt++; if (!seen || n !== 17) $display("FAIL tmo_latency: got %0d cycles (start=%b) want 17", n, seen); else pass_cnt++;
    total_cnt++; if (Ack !== 4'b0010 || Err !== 1'b1) $display("FAIL tmo_ack_err: got %b/%b want 0010/1", Ack, Err); else pass_cnt++;
    total_cnt++; if (RxData !== 8'h3C) $display("FAIL tmo_rx_hold: got %h want 3c", RxData); else pass_cnt++;
    Req = 4'b0000; stuck = 1'b0;
    @(negedge Clk);
    total_cnt++; if (Err !== 1'b0 || Ack !== 4'b0000) $display("FAIL tmo_err_pulse: got %b/%b want 0/0000", Err, Ack); else pass_cnt++;
    rx_value = 8'h96;
    Req = 4'b1000;
    wait_ack(30, ok);
    total_cnt++; if (!ok || Ack !== 4'b1000 || Err !== 1'b0 || RxData !== 8'h96) $display("FAIL tmo_recover: got %b/%b/%h want 1000/0/96", Ack, Err, RxData); else pass_cnt++;
    Req = 4'b0000;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_data_change;
    bit ok;
    int base;
    rx_value = 8'h81;
    Req = 4'b0100;
    repeat (3) @(negedge Clk);
    ReqTxData[23:16] = 8'hFF;
    Req = 4'b0000;
    @(negedge Clk);
    total_cnt++; if (SpiTxData !== 8'hA5 || Grant !== 4'b0100) $display("FAIL chg_latched: got %h/%b want a5/0100", SpiTxData, Grant); else pass_cnt++;
    base = start_cnt;
    wait_ack(30, ok);
    total_cnt++; if (!ok || Ack !== 4'b0100 || RxData !== 8'h81) $display("FAIL chg_ack: got %b/%h (ok=%b) want 0100/81", Ack, RxData, ok); else pass_cnt++;
    repeat (6) @(negedge Clk);
    total_cnt++; if (Grant !== 4'b0000 || Busy !== 1'b0 || start_cnt !== base) $display("FAIL chg_no_regrant: got %b/%b/%0d want 0000/0/%0d", Grant, Busy, start_cnt, base); else pass_cnt++;
    ReqTxData[23:16] = 8'hA5;
  endtask

  task automatic test_reset_mid;
    bit seen;
    Req = 4'b0010;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (m_ss == 1'b0) begin seen = 1'b1; break; end
    end
    @(negedge Clk);
    total_cnt++; if (!seen || Grant !== 4'b0010 || SsOut !== 4'b1101) $display("FAIL rstmid_pre: got %b/%b (seen=%b) want 0010/1101", Grant, SsOut, seen); else pass_cnt++;
    Reset = 1'b1;
    #1;
    total_cnt++; if (Grant !== 4'b0000 || Busy !== 1'b0 || SsOut !== 4'b1111) $display("FAIL rstmid_clear: got %b/%b/%b want 0000/0/1111", Grant, Busy, SsOut); else pass_cnt++;
    Req = 4'b1111;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    total_cnt++; if (Grant !== 4'b0001 || SpiTxData !== 8'h11) $display("FAIL rstmid_first: got %b/%h want 0001/11", Grant, SpiTxData); else pass_cnt++;
    Req = 4'b0000;
    repeat (15) @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_timeout();
    test_data_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, total_cnt);
    $fatal(1);
  end

endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Shares one spi_master instance among NUM_REQ independent requesters.
- Round-robin arbitration: each requester owns one slave-select line.
- Latches the winner's TxData and ClkDiv, drives the master's Start/TxData/ClkDiv, and tracks the master's Done handshake.
- Returns RxData with a one-cycle Ack to the winner, then fans the master's SS out to the granted requester's slave.

Parameters:
- NUM_REQ, 4, number of requesters/slaves (2..8).
- DATA_WIDTH, 8, SPI word width; must match the attached master.
- TIMEOUT, 15, max Clk cycles in WAIT_BUSY for master Done to fall before abort (1..255).

Ports:
- Clk  in  1  system clock (same clock as the master).
- Reset  in  1  asynchronous, active-high.
- Req  in  NUM_REQ  level request per requester; held until Ack.
- ReqTxData  in  NUM_REQ*DATA_WIDTH  per-requester transmit word; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- ReqClkDiv  in  NUM_REQ*2  per-requester clock divider code; slice i = bits [2i +: 2].
- Grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- Ack  out  NUM_REQ  one-cycle completion pulse to the owner.
- Err  out  1  one-cycle pulse coincident with Ack on timeout abort.
- RxData  out  DATA_WIDTH  received word; valid when any Ack bit is 1, holds until the next completion.
- Busy  out  1  high in any state other than IDLE.
- SpiStart  out  1  to master Start.
- SpiTxData  out  DATA_WIDTH  to master TxData; latched.
- SpiClkDiv  out  2  to master ClkDiv; latched.
- SpiDone  in  1  from master Done (1 when master idle).
- SpiRxData  in  DATA_WIDTH  from master RxData.
- SpiSS  in  1  from master SS, active low.
- SsOut  out  NUM_REQ  per-slave select, active low.

Behaviour:
- Reset values:
  - Grant=0, Ack=0, Err=0, RxData=0, Busy=0, SpiStart=0, SpiTxData=0, SpiClkDiv=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - State IDLE, timeout counter 0.
- SsOut is combinational: SsOut[i] = SpiSS when Grant[i]=1, else 1. All SsOut bits are 1 when Grant=0.
- FSM, all outputs registered except SsOut:
  - IDLE:
    - If Req≠0, pick the first set Req bit scanning last+1, last+2, … modulo NUM_REQ.
    - Grant<=onehot(winner); latch that requester's TxData slice into SpiTxData and its ClkDiv slice into SpiClkDiv.
    - SpiStart<=1; go START.
  - START:
    - SpiStart is high for exactly this one cycle; SpiStart<=0.
    - Clear timeout counter; go WAIT_BUSY.
  - WAIT_BUSY:
    - SpiDone=0 -> WAIT_DONE.
    - Else counter increments; when counter reaches TIMEOUT -> ABORT.
  - WAIT_DONE:
    - SpiDone=1 -> COMPLETE. No timeout in this state.
  - COMPLETE:
    - RxData<=SpiRxData; Ack<=Grant (one cycle); Grant<=0; last<=winner index; go GAP.
  - ABORT:
    - Ack<=Grant, Err<=1 (one cycle); RxData unchanged; Grant<=0; last<=winner; go GAP.
  - GAP:
    - One idle cycle so the master returns to IDLE before the next Start; go IDLE.
    - Req is not sampled in GAP.
- Latency, Req rise in IDLE to SpiStart=1: 1 cycle. Minimum spacing between back-to-back SpiStart pulses: transfer time + 4 cycles.
- Req and data inputs are sampled only in IDLE:
  - Later changes to ReqTxData/ReqClkDiv do not affect an in-flight transfer.
  - If the owner drops Req mid-transfer, the transfer completes and Ack still pulses.
- The winner's Req is still high during Ack. The requester must drop it in the Ack cycle or it is re-queued (it loses priority to the others).
- Simultaneous Req: exactly one grant; all other Req bits wait with no starvation. Worst-case wait is NUM_REQ-1 transfers.
- Reset mid-transfer: all outputs return to reset values immediately and SsOut goes all-1. The master is reset by the same Reset.

Test Plan:
- Single request: Req=4'b0100, ReqTxData slice2=8'hA5, ReqClkDiv slice2=2'b00, loopback model returns 8'h3C.
  -> Grant=4'b0100; SpiStart high 1 cycle; SpiTxData=8'hA5; SsOut=4'b1011 while SpiSS=0; Ack=4'b0100 with RxData=8'h3C; Err=0.
- All four Req held high from reset.
  -> Grant order 0001, 0010, 0100, 1000, 0001; exactly one SpiStart per Ack.
- Req 0 and 2 high after requester 0 was just served.
  -> Grant goes to 2 first, then 0.
- Master model holds SpiDone=1 after Start, TIMEOUT=15.
  -> ABORT after 15 WAIT_BUSY cycles; Ack and Err pulse together; RxData keeps its previous value; next request is granted normally.
- Owner changes ReqTxData to 8'hFF and drops Req mid-transfer.
  -> SpiTxData stays 8'hA5; Ack still pulses; no new grant for that requester.
- Reset asserted during WAIT_DONE.
  -> Same cycle: Grant=0, Busy=0, SsOut=all-1. After release, the first grant goes to requester 0 when all Req are high.
